// File: rtl/load_store_unit.sv
// load_store_unit: bus initiator between the memory stage and the byte-addressable
// data memory. It takes one request at a time, checks alignment and range, and
// sequences the level-sensitive memRead/memWrite strobes around a stable
// address/size/data bundle. Load data is byte-reordered and zero/sign-extended.
//
// Handshake: a request transfers on the rising edge where reqValid && reqReady.
// reqReady is high only in IDLE (and never while resetN is low). reqValid seen in
// any other state is ignored. The response is a single-cycle respValid pulse with
// respData/respError valid in that same cycle; there is no back-pressure on it.
module load_store_unit #(
    parameter int dataWidth    = 32,
    parameter int memBytes     = 512,
    parameter int accessCycles = 1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic                 reqSigned,
    input  logic [1:0]           reqSize,
    input  logic [dataWidth-1:0] reqAddr,
    input  logic [dataWidth-1:0] reqData,
    output logic                 respValid,
    output logic [dataWidth-1:0] respData,
    output logic                 respError,
    output logic                 memRead,
    output logic                 memWrite,
    output logic [1:0]           sizeSignal,
    output logic [dataWidth-1:0] address,
    output logic [dataWidth-1:0] writeData,
    input  logic [dataWidth-1:0] readData
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        RELEASE = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Count value on the final strobe cycle of an access.
    localparam logic [3:0]         LAST_CNT = 4'(accessCycles - 1);
    // One past the last legal byte address, widened so reqAddr + bytes cannot wrap.
    localparam logic [dataWidth:0] MEM_END  = (dataWidth + 1)'(memBytes);

    state_e                 state_q,  state_d;
    logic                   write_q,  write_d;
    logic                   signed_q, signed_d;
    logic [1:0]             size_q,   size_d;
    logic [dataWidth-1:0]   addr_q,   addr_d;
    logic [dataWidth-1:0]   data_q,   data_d;
    logic [dataWidth-1:0]   result_q, result_d;
    logic                   err_q,    err_d;
    logic [3:0]             cnt_q,    cnt_d;

    logic [2:0]             req_bytes;
    logic [dataWidth:0]     req_end;
    logic                   req_err;

    // Memory returns the lowest-address byte in the most significant returned lane;
    // swap back to little-endian, then extend sub-word loads.
    function automatic logic [dataWidth-1:0] load_format(
        input logic [dataWidth-1:0] rd,
        input logic [1:0]           sz,
        input logic                 sg
    );
        logic [dataWidth-1:0] r;
        r = '0;
        case (sz)
            2'd0:    r = {{(dataWidth - 8){sg & rd[7]}}, rd[7:0]};
            2'd1:    r = {{(dataWidth - 16){sg & rd[7]}}, rd[7:0], rd[15:8]};
            default: r[31:0] = {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
        endcase
        return r;
    endfunction

    // Request legality: illegal size, misalignment, or running past the memory end.
    always_comb begin
        req_bytes = 3'd0;
        case (reqSize)
            2'd0:    req_bytes = 3'd1;
            2'd1:    req_bytes = 3'd2;
            2'd2:    req_bytes = 3'd4;
            default: req_bytes = 3'd0;
        endcase
        req_end = {1'b0, reqAddr} + {{(dataWidth - 2){1'b0}}, req_bytes};
        req_err = (reqSize == 2'd3)
                | ((reqSize == 2'd1) && reqAddr[0])
                | ((reqSize == 2'd2) && (reqAddr[1:0] != 2'b00))
                | (req_end > MEM_END);
    end

    // Next-state and datapath update for the access sequencer.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        signed_d = signed_q;
        size_d   = size_q;
        addr_d   = addr_q;
        data_d   = data_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    write_d  = reqWrite;
                    signed_d = reqSigned;
                    size_d   = reqSize;
                    addr_d   = reqAddr;
                    data_d   = reqData;
                    result_d = '0;
                    err_d    = req_err;
                    state_d  = req_err ? RESP : SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    if (!write_q) begin
                        result_d = load_format(readData, size_q, signed_q);
                    end
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RELEASE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decoded from state; strobes only in ACCESS, so they are exclusive
    // and the address bundle (held in registers) never moves under a strobe.
    always_comb begin
        reqReady   = resetN && (state_q == IDLE);
        memRead    = (state_q == ACCESS) && !write_q;
        memWrite   = (state_q == ACCESS) && write_q;
        address    = addr_q;
        sizeSignal = size_q;
        writeData  = data_q;
        respValid  = (state_q == RESP);
        respError  = (state_q == RESP) && err_q;
        respData   = (state_q == RESP) ? result_q : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (accessCycles 1 and 3), each attached to
// a byte-array memory that returns multi-byte reads lowest-address byte first.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid1, reqValid3;
    logic        reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqData;

    logic        reqReady1, respValid1, respError1, memRead1, memWrite1;
    logic [31:0] respData1, address1, writeData1, readData1;
    logic [1:0]  sizeSignal1;
    logic        reqReady3, respValid3, respError3, memRead3, memWrite3;
    logic [31:0] respData3, address3, writeData3, readData3;
    logic [1:0]  sizeSignal3;

    logic [7:0]  mem1 [0:511] = '{default: 8'h00};
    logic [7:0]  mem3 [0:511] = '{default: 8'h00};
    logic [8:0]  ma1, ma3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.dataWidth(32), .memBytes(512), .accessCycles(1)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid1), .reqReady(reqReady1),
        .reqWrite(reqWrite), .reqSigned(reqSigned), .reqSize(reqSize),
        .reqAddr(reqAddr), .reqData(reqData), .respValid(respValid1),
        .respData(respData1), .respError(respError1), .memRead(memRead1),
        .memWrite(memWrite1), .sizeSignal(sizeSignal1), .address(address1),
        .writeData(writeData1), .readData(readData1)
    );

    load_store_unit #(.dataWidth(32), .memBytes(512), .accessCycles(3)) dut3 (
        .clk(clk), .resetN(resetN), .reqValid(reqValid3), .reqReady(reqReady3),
        .reqWrite(reqWrite), .reqSigned(reqSigned), .reqSize(reqSize),
        .reqAddr(reqAddr), .reqData(reqData), .respValid(respValid3),
        .respData(respData3), .respError(respError3), .memRead(memRead3),
        .memWrite(memWrite3), .sizeSignal(sizeSignal3), .address(address3),
        .writeData(writeData3), .readData(readData3)
    );

    assign ma1 = address1[8:0];
    assign ma3 = address3[8:0];

    // Memory models: reads present the lowest-address byte in the top returned lane.
    always_comb begin
        readData1 = 32'h0;
        if (memRead1) begin
            case (sizeSignal1)
                2'd0:    readData1 = {24'h0, mem1[ma1]};
                2'd1:    readData1 = {16'h0, mem1[ma1], mem1[ma1 + 9'd1]};
                default: readData1 = {mem1[ma1], mem1[ma1 + 9'd1], mem1[ma1 + 9'd2], mem1[ma1 + 9'd3]};
            endcase
        end
    end

    always_comb begin
        readData3 = 32'h0;
        if (memRead3) begin
            case (sizeSignal3)
                2'd0:    readData3 = {24'h0, mem3[ma3]};
                2'd1:    readData3 = {16'h0, mem3[ma3], mem3[ma3 + 9'd1]};
                default: readData3 = {mem3[ma3], mem3[ma3 + 9'd1], mem3[ma3 + 9'd2], mem3[ma3 + 9'd3]};
            endcase
        end
    end

    // Stores commit little-endian, consuming only the low bytes for the size.
    always @(posedge clk) begin
        if (memWrite1) begin
            mem1[ma1] <= writeData1[7:0];
            if (sizeSignal1 != 2'd0) mem1[ma1 + 9'd1] <= writeData1[15:8];
            if (sizeSignal1 == 2'd2) begin
                mem1[ma1 + 9'd2] <= writeData1[23:16];
                mem1[ma1 + 9'd3] <= writeData1[31:24];
            end
        end
        if (memWrite3) begin
            mem3[ma3] <= writeData3[7:0];
            if (sizeSignal3 != 2'd0) mem3[ma3 + 9'd1] <= writeData3[15:8];
            if (sizeSignal3 == 2'd2) begin
                mem3[ma3 + 9'd2] <= writeData3[23:16];
                mem3[ma3 + 9'd3] <= writeData3[31:24];
            end
        end
    end

    // Driver: issues one request to instance sel (0: 1-cycle, 1: 3-cycle) and
    // observes it at each negedge until the response (lat = cycles after acceptance).
    task automatic do_req(
        input  bit          sel,
        input  bit          wr,
        input  bit          sg,
        input  logic [1:0]  sz,
        input  logic [31:0] ad,
        input  logic [31:0] dt,
        input  bit          hold_busy,
        output logic [31:0] r_data,
        output logic        r_err,
        output int          lat,
        output int          rd_cyc,
        output int          wr_cyc,
        output bit          bundle_ok,
        output bit          ready_after,
        output bit          busy_ready,
        output bit          both_strobes
    );
        logic        c_rv, c_ready, c_mr, c_mw;
        logic [65:0] c_bundle, first_bundle;
        lat = -1; rd_cyc = 0; wr_cyc = 0; bundle_ok = 1'b1; ready_after = 1'b0;
        busy_ready = 1'b0; both_strobes = 1'b0; r_data = 32'hx; r_err = 1'bx;
        first_bundle = '0;
        @(negedge clk);
        reqWrite = wr; reqSigned = sg; reqSize = sz; reqAddr = ad; reqData = dt;
        if (sel) reqValid3 = 1'b1; else reqValid1 = 1'b1;
        for (int i = 0; i < 20 && !(sel ? reqReady3 : reqReady1); i++) @(negedge clk);
        @(posedge clk);
        #1;
        if (hold_busy) begin
            reqWrite = 1'b1; reqSize = 2'd2; reqAddr = 32'h44; reqData = 32'hFFFF_FFFF;
        end else begin
            reqValid1 = 1'b0; reqValid3 = 1'b0;
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            c_rv     = sel ? respValid3 : respValid1;
            c_ready  = sel ? reqReady3 : reqReady1;
            c_mr     = sel ? memRead3 : memRead1;
            c_mw     = sel ? memWrite3 : memWrite1;
            c_bundle = sel ? {address3, sizeSignal3, writeData3} : {address1, sizeSignal1, writeData1};
            if (k == 1) first_bundle = c_bundle;
            else if (!c_rv && (c_bundle !== first_bundle)) bundle_ok = 1'b0;
            if (c_mr) rd_cyc++;
            if (c_mw) wr_cyc++;
            if (c_mr && c_mw) both_strobes = 1'b1;
            if (c_ready) busy_ready = 1'b1;
            if (c_rv) begin
                lat    = k;
                r_data = sel ? respData3 : respData1;
                r_err  = sel ? respError3 : respError1;
                reqValid1 = 1'b0; reqValid3 = 1'b0;
                break;
            end
        end
        reqValid1 = 1'b0; reqValid3 = 1'b0;
        @(negedge clk);
        ready_after = sel ? reqReady3 : reqReady1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; reqValid1 = 1'b0; reqValid3 = 1'b0;
        reqWrite = 1'b0; reqSigned = 1'b0; reqSize = 2'd0; reqAddr = 32'h0; reqData = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (reqReady1 !== 1'b0) begin failures++; $display("FAIL reset_ready1: got %b expected 0", reqReady1); end
        checks++; if (reqReady3 !== 1'b0) begin failures++; $display("FAIL reset_ready3: got %b expected 0", reqReady3); end
        checks++; if ({respValid1, respError1, memRead1, memWrite1} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b expected 0000", {respValid1, respError1, memRead1, memWrite1}); end
        checks++; if ({address1, writeData1, respData1, sizeSignal1} !== 98'h0) begin failures++; $display("FAIL reset_buses: got %h expected 0", {address1, writeData1, respData1, sizeSignal1}); end
        resetN = 1'b1;
        @(negedge clk);
        checks++; if ({reqReady1, reqReady3} !== 2'b11) begin failures++; $display("FAIL reset_release_ready: got %b expected 11", {reqReady1, reqReady3}); end
    endtask

    task automatic test_word();
        logic [31:0] d; logic e; int lat, rc, wc; bit bok, rdy, br, bs;
        do_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if (lat !== 4) begin failures++; $display("FAIL word_store_latency: got %0d expected 4", lat); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL word_store_err: got %b expected 0", e); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL word_store_data: got %h expected 0", d); end
        checks++; if ({wc, rc} !== {32'd1, 32'd0}) begin failures++; $display("FAIL word_store_strobes: wr %0d rd %0d expected 1 0", wc, rc); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL word_store_bundle_stable: got %b expected 1", bok); end
        checks++; if ({mem1[16], mem1[17], mem1[18], mem1[19]} !== 32'hEFBEADDE) begin failures++; $display("FAIL word_store_mem: got %h expected efbeadde", {mem1[16], mem1[17], mem1[18], mem1[19]}); end
        checks++; if ({rdy, br, bs} !== 3'b100) begin failures++; $display("FAIL word_store_ready: got %b expected 100", {rdy, br, bs}); end
        do_req(1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_data: got %h expected deadbeef", d); end
        checks++; if ({e, lat} !== {1'b0, 32'd4}) begin failures++; $display("FAIL word_load_err_lat: err %b lat %0d expected 0 4", e, lat); end
        checks++; if ({rc, wc} !== {32'd1, 32'd0}) begin failures++; $display("FAIL word_load_strobes: rd %0d wr %0d expected 1 0", rc, wc); end
    endtask

    task automatic test_byte_half();
        logic [31:0] d; logic e; int lat, rc, wc; bit bok, rdy, br, bs;
        do_req(1'b0, 1'b1, 1'b0, 2'd0, 32'h2E, 32'h00000080, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, mem1[46], mem1[47]} !== {1'b0, 8'h80, 8'h00}) begin failures++; $display("FAIL byte_store: err %b mem %h %h expected 0 80 00", e, mem1[46], mem1[47]); end
        do_req(1'b0, 1'b0, 1'b1, 2'd0, 32'h2E, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_load_signed: got %h expected ffffff80", d); end
        do_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h2E, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if (d !== 32'h00000080) begin failures++; $display("FAIL byte_load_unsigned: got %h expected 00000080", d); end
        do_req(1'b0, 1'b1, 1'b0, 2'd1, 32'h20, 32'h00008001, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, mem1[32], mem1[33]} !== {1'b0, 8'h01, 8'h80}) begin failures++; $display("FAIL half_store: err %b mem %h %h expected 0 01 80", e, mem1[32], mem1[33]); end
        do_req(1'b0, 1'b0, 1'b1, 2'd1, 32'h20, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if (d !== 32'hFFFF8001) begin failures++; $display("FAIL half_load_signed: got %h expected ffff8001", d); end
        do_req(1'b0, 1'b0, 1'b0, 2'd1, 32'h20, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if (d !== 32'h00008001) begin failures++; $display("FAIL half_load_unsigned: got %h expected 00008001", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int lat, rc, wc; bit bok, rdy, br, bs;
        logic        t_wr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  t_sz [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2};
        logic [31:0] t_ad [6] = '{32'h21, 32'h1FE, 32'h0, 32'h200, 32'h200, 32'h2};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, t_wr[i], 1'b1, t_sz[i], t_ad[i], 32'hCAFEF00D, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
            checks++; if ({e, lat} !== {1'b1, 32'd1}) begin failures++; $display("FAIL err_%0d_flag_lat: err %b lat %0d expected 1 1", i, e, lat); end
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL err_%0d_data: got %h expected 0", i, d); end
            checks++; if ({rc, wc} !== 64'h0) begin failures++; $display("FAIL err_%0d_strobes: rd %0d wr %0d expected 0 0", i, rc, wc); end
            checks++; if ({rdy, br} !== 2'b10) begin failures++; $display("FAIL err_%0d_ready: got %b expected 10", i, {rdy, br}); end
        end
        checks++; if ({mem1[510], mem1[511]} !== 16'h0) begin failures++; $display("FAIL err_store_mem: got %h expected 0", {mem1[510], mem1[511]}); end
    endtask

    task automatic test_boundary();
        logic [31:0] d; logic e; int lat, rc, wc; bit bok, rdy, br, bs;
        do_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h1FC, 32'hA1B2C3D4, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, lat, wc} !== {1'b0, 32'd4, 32'd1}) begin failures++; $display("FAIL top_word_store: err %b lat %0d wr %0d expected 0 4 1", e, lat, wc); end
        do_req(1'b0, 1'b0, 1'b0, 2'd2, 32'h1FC, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, d} !== {1'b0, 32'hA1B2C3D4}) begin failures++; $display("FAIL top_word_load: err %b data %h expected 0 a1b2c3d4", e, d); end
        do_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h1FF, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, d} !== {1'b0, 32'h000000A1}) begin failures++; $display("FAIL top_byte_load: err %b data %h expected 0 000000a1", e, d); end
        do_req(1'b0, 1'b0, 1'b1, 2'd1, 32'h1FE, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, d} !== {1'b0, 32'hFFFFA1B2}) begin failures++; $display("FAIL top_half_load: err %b data %h expected 0 ffffa1b2", e, d); end
    endtask

    task automatic test_slow_busy();
        logic [31:0] d; logic e; int lat, rc, wc; bit bok, rdy, br, bs;
        do_req(1'b1, 1'b1, 1'b0, 2'd2, 32'h40, 32'h12345678, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({lat, wc, rc} !== {32'd6, 32'd3, 32'd0}) begin failures++; $display("FAIL slow_store: lat %0d wr %0d rd %0d expected 6 3 0", lat, wc, rc); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL slow_store_bundle_stable: got %b expected 1", bok); end
        do_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({lat, rc, wc} !== {32'd6, 32'd3, 32'd0}) begin failures++; $display("FAIL slow_load: lat %0d rd %0d wr %0d expected 6 3 0", lat, rc, wc); end
        checks++; if ({e, d} !== {1'b0, 32'h12345678}) begin failures++; $display("FAIL slow_load_data: err %b data %h expected 0 12345678", e, d); end
        checks++; if ({br, bs, bok, rdy} !== 4'b0011) begin failures++; $display("FAIL slow_busy_ignore: got %b expected 0011", {br, bs, bok, rdy}); end
        checks++; if ({mem3[68], mem3[69], mem3[70], mem3[71]} !== 32'h0) begin failures++; $display("FAIL slow_busy_no_write: got %h expected 0", {mem3[68], mem3[69], mem3[70], mem3[71]}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int lat, rc, wc; bit bok, rdy, br, bs; bit seen;
        @(negedge clk);
        reqWrite = 1'b0; reqSigned = 1'b0; reqSize = 2'd2; reqAddr = 32'h10; reqData = 32'h0;
        reqValid1 = 1'b1;
        @(posedge clk);
        #1 reqValid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (memRead1 !== 1'b1) begin failures++; $display("FAIL mid_access_strobe: got %b expected 1", memRead1); end
        resetN = 1'b0;
        @(negedge clk);
        checks++; if ({memRead1, memWrite1, respValid1, reqReady1} !== 4'b0) begin failures++; $display("FAIL mid_reset_outputs: got %b expected 0000", {memRead1, memWrite1, respValid1, reqReady1}); end
        resetN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (respValid1 || memRead1 || memWrite1) seen = 1'b1;
        end
        checks++; if ({seen, reqReady1} !== 2'b01) begin failures++; $display("FAIL mid_reset_quiet: got %b expected 01", {seen, reqReady1}); end
        do_req(1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, d, e, lat, rc, wc, bok, rdy, br, bs);
        checks++; if ({e, lat, d} !== {1'b0, 32'd4, 32'hDEADBEEF}) begin failures++; $display("FAIL mid_reset_reload: err %b lat %0d data %h expected 0 4 deadbeef", e, lat, d); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_boundary();
        test_slow_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
